biu_cycle_engine: RTL

BIU_CYCLE_ENGINE -- requirements
Module: biu_cycle_engine

---
 rtl/biu_cycle_engine.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/biu_cycle_engine.sv
// biu_cycle_engine: multiplexed address/data bus cycle engine (T1..T4 with wait states).
// Accepts one transfer request at a time and runs a single bus cycle for it:
//   T1 address + ALE, T2 strobes, T3/TW sample READY, T4 strobes off + response.
// Optional feature macro: HOLD_ARB_EN compiles in HOLD/HLDA bus arbitration (HLD state).
// Bus-control outputs and response outputs are registered; req_ready is decoded from the
// state register so a request can be taken on the first edge after reset.
module biu_cycle_engine #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                     CLK,
  input  logic                     RESET,

  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic                     req_io,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,

  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,

  output logic                     ALE,
  output logic                     RD,
  output logic                     WR,
  output logic                     DEN,
  output logic                     DTR,
  output logic                     IOM,

  output logic [DATA_W-1:0]        AD_out,
  output logic                     AD_oe,
  input  logic [DATA_W-1:0]        AD_in,
  output logic [ADDR_W-DATA_W-1:0] A_out,

  input  logic                     READY,
  input  logic                     HOLD,
  output logic                     HLDA
);

  localparam int unsigned HI_W       = ADDR_W - DATA_W;
  localparam int unsigned WCNT_W     = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX = {WCNT_W{1'b1}};
  localparam logic [WCNT_W-1:0] WCNT_LIM = WCNT_W'(MAX_WAIT);
  localparam bit          TIMEOUT_EN = (MAX_WAIT != 0);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_TW   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
`ifdef HOLD_ARB_EN
  localparam logic [2:0] S_HLD  = 3'd6;
`endif

  logic [2:0]        state, state_n;
  logic [WCNT_W-1:0] wcnt, wcnt_n;
  logic              lat_write, lat_write_n;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_n;

  logic              ale_n, rd_n, wr_n, den_n, dtr_n, iom_n, oe_n;
  logic [DATA_W-1:0] ad_n;
  logic [HI_W-1:0]   a_n;
  logic              vld_n, err_n;
  logic [DATA_W-1:0] rdata_n;
  logic              strobe;
`ifdef HOLD_ARB_EN
  logic              hlda_n;
`endif

  // Ready is a pure state decode; a pending HOLD masks it so HOLD wins in IDLE.
`ifdef HOLD_ARB_EN
  assign req_ready = (state == S_IDLE) && !HOLD && !RESET;
`else
  logic unused_hold;
  assign unused_hold = HOLD;
  assign req_ready   = (state == S_IDLE) && !RESET;
  assign HLDA        = 1'b0;
`endif

  // Next state, wait counter, request latches and next values of the registered outputs.
  always_comb begin
    state_n     = state;
    wcnt_n      = wcnt;
    lat_write_n = lat_write;
    lat_wdata_n = lat_wdata;
    ale_n       = 1'b0;
    rd_n        = 1'b1;
    wr_n        = 1'b1;
    den_n       = 1'b1;
    oe_n        = 1'b0;
    ad_n        = AD_out;
    a_n         = A_out;
    iom_n       = IOM;
    dtr_n       = DTR;
    vld_n       = 1'b0;
    err_n       = 1'b0;
    rdata_n     = rsp_rdata;
    strobe      = 1'b0;
`ifdef HOLD_ARB_EN
    hlda_n      = 1'b0;
`endif

    case (state)
      S_IDLE: begin
`ifdef HOLD_ARB_EN
        if (HOLD) begin
          state_n = S_HLD;
          hlda_n  = 1'b1;
        end else
`endif
        if (req_valid) begin
          state_n     = S_T1;
          lat_write_n = req_write;
          lat_wdata_n = req_wdata;
          ale_n       = 1'b1;
          oe_n        = 1'b1;
          ad_n        = req_addr[DATA_W-1:0];
          a_n         = req_addr[ADDR_W-1:DATA_W];
          iom_n       = req_io;
          dtr_n       = req_write;
        end
      end

      S_T1: begin
        state_n = S_T2;
        wcnt_n  = '0;
        strobe  = 1'b1;
      end

      S_T2: begin
        state_n = S_T3;
        strobe  = 1'b1;
      end

      // READY has priority over the timeout on the last allowed wait state.
      S_T3, S_TW: begin
        if (READY) begin
          state_n = S_T4;
          vld_n   = 1'b1;
          if (!lat_write) begin
            rdata_n = AD_in;
          end
        end else if (TIMEOUT_EN && (state == S_TW) && (wcnt == WCNT_LIM)) begin
          state_n = S_T4;
          vld_n   = 1'b1;
          err_n   = 1'b1;
          rdata_n = '0;
        end else begin
          state_n = S_TW;
          strobe  = 1'b1;
          if (wcnt != WCNT_MAX) begin
            wcnt_n = wcnt + WCNT_W'(1);
          end
        end
      end

      S_T4: begin
        state_n = S_IDLE;
      end

`ifdef HOLD_ARB_EN
      S_HLD: begin
        if (HOLD) begin
          hlda_n = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
`endif

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Data phase strobes, shared by T2, T3 and TW.
    if (strobe) begin
      den_n = 1'b0;
      if (lat_write) begin
        wr_n = 1'b0;
        oe_n = 1'b1;
        ad_n = lat_wdata;
      end else begin
        rd_n = 1'b0;
      end
    end
  end

  // State, latches and registered outputs; reset forces the bus idle and aborts any cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      ALE       <= 1'b0;
      RD        <= 1'b1;
      WR        <= 1'b1;
      DEN       <= 1'b1;
      DTR       <= 1'b0;
      IOM       <= 1'b0;
      AD_oe     <= 1'b0;
      AD_out    <= '0;
      A_out     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
`ifdef HOLD_ARB_EN
      HLDA      <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      wcnt      <= wcnt_n;
      lat_write <= lat_write_n;
      lat_wdata <= lat_wdata_n;
      ALE       <= ale_n;
      RD        <= rd_n;
      WR        <= wr_n;
      DEN       <= den_n;
      DTR       <= dtr_n;
      IOM       <= iom_n;
      AD_oe     <= oe_n;
      AD_out    <= ad_n;
      A_out     <= a_n;
      rsp_valid <= vld_n;
      rsp_err   <= err_n;
      rsp_rdata <= rdata_n;
`ifdef HOLD_ARB_EN
      HLDA      <= hlda_n;
`endif
    end
  end

endmodule
